fight_round_ctrl: RTL and testbench
===================================

Name: fight_round_ctrl

Overview:
Match and round sequencer for the two fighter animation FSMs and the HUD. It runs the round phases (intro, fight, KO/timeout, match over) and owns both health bars, both special meters (the KS value fed to each fighter) and the round clock. It gates fighter key inputs and drives each fighter's isdead. All game state advances on the frame tick; it sits between the keyboard decoder, the two fighter FSMs and the HUD renderer.

Parameters:
HP_MAX, 100, starting health per round (fits 8 bits)
MELEE_DMG, 8, health removed per qualifying melee hit
PROJ_DMG, 30, health removed per projectile hit
KS_MAX, 200, special-meter ceiling; fighter may fire special only at exactly this value
KS_GAIN, 20, meter gained by attacker per landed melee hit
ROUND_SECS, 99, round clock start value
FRAMES_PER_SEC, 60, frame ticks per clock second
INTRO_FRAMES, 120, ticks spent in INTRO
KO_FRAMES, 180, ticks spent in KO/TIMEOUT
WINS_NEEDED, 2, round wins that end the match

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  vertical-sync frame clock; rising edge = one tick
start  in  1  level, sampled on tick; starts or restarts a match
key_p1, key_p2  in  14  raw key vectors: [7] special, [8] kick, [9] punch, [10] right, [11] crouch, [12] left, [13] jump
hit_p1, hit_p2  in  1  fighter hit flag; held for one frame, sampled on tick
in_range  in  1  fighters within melee range (from position logic)
proj_hit_p1, proj_hit_p2  in  1  projectile launched by Pn struck opponent, sampled on tick
gen_p1, gen_p2  in  1  fighter special-launch flag; consumes meter
key_out_p1, key_out_p2  out  14  gated key vectors to fighters
ks_p1, ks_p2  out  10  special meter
hp_p1, hp_p2  out  8  health
isdead_p1, isdead_p2  out  1  KO indication to fighter FSM
timer  out  7  round seconds remaining
wins_p1, wins_p2  out  2  rounds won
phase  out  3  current phase_t
winner  out  2  0 none, 1 P1, 2 P2; valid in MATCH_OVER

Behaviour:
- Reset (async): phase IDLE; hp=HP_MAX; ks=0; timer=ROUND_SECS; wins=0; isdead=0; winner=0; frame/sub-second counters=0. Reset mid-round aborts to this state immediately.
- Tick: a two-flop edge detect on frame_clk in the Clk domain. The tick is one Clk cycle wide. Every state and register update below occurs only on tick cycles.
- key_out_pn = key_pn when phase==FIGHT, else 0. This path is combinational, with zero latency.
- IDLE: start=1 -> INTRO.
- INTRO: hp=HP_MAX, ks=0, timer=ROUND_SECS, isdead=0, all loaded on entry. Stays INTRO_FRAMES ticks, then -> FIGHT.
- FIGHT, per tick:
  - Damage to P2 is (hit_p1&&in_range ? MELEE_DMG : 0) + (proj_hit_p1 ? PROJ_DMG : 0). The result saturates at 0, never wraps. P1 is symmetric.
  - ks_p1 += KS_GAIN on a qualifying melee hit by P1, saturating at KS_MAX.
  - gen_p1=1 clears ks_p1 to 0. If gen and a gain occur on the same tick, the clear wins.
  - Hits from both players on the same tick are both applied.
  - The sub-second counter wraps at FRAMES_PER_SEC-1 and then decrements timer.
- Leaving FIGHT (evaluated on the post-update values, in this priority):
  - Any hp==0: -> KO; isdead_pn=1 for each dead player. A single KO increments the survivor's wins. A double KO awards no win.
  - Otherwise timer==0: -> TIMEOUT. Higher hp wins the round; equal hp awards no win; isdead stays 0.
- KO/TIMEOUT: counts KO_FRAMES ticks. Then, if a wins counter equals WINS_NEEDED: -> MATCH_OVER and set winner. Otherwise -> INTRO (isdead drops on INTRO entry).
- MATCH_OVER: holds all outputs. start=1 clears wins and winner, then -> INTRO.
- wins saturates at WINS_NEEDED and never increments twice per round.
- Inputs outside FIGHT are ignored: hits, projectiles and gen.

Decomposition:
- Package fight_pkg holds:
  - phase_t enum: IDLE=0, INTRO=1, FIGHT=2, KO=3, TIMEOUT=4, MATCH_OVER=5.
  - Key bit index constants: KEY_SPESH=7, KEY_KICK=8, KEY_PUNCH=9, KEY_RIGHT=10, KEY_CROUCH=11, KEY_LEFT=12, KEY_JUMP=13.
  - Widths: HP_W=8, KS_W=10.
- Sub-module fighter_stats is instantiated once per player. It owns the hp and ks registers with saturating damage, gain and clear logic, plus load-on-INTRO.

Test Plan:
- Reset; start=1 for 1 tick -> phase INTRO for 120 ticks, then FIGHT; hp 100/100, timer 99; key_out is 0 until FIGHT.
- hit_p1=1, in_range=1 for 13 ticks -> hp_p2 steps 92, 84 … 4, then 0 on the 13th tick (no wrap). phase KO, isdead_p2=1, wins_p1=1. ks_p1 is 200 after the 10th hit and holds at 200.
- ks_p1=200; on one tick gen_p1=1 and a qualifying hit_p1=1 -> ks_p1=0, hp_p2 -=8. proj_hit_p1 on the next tick -> hp_p2 -=30.
- hp 4/4; hit_p1, hit_p2, in_range all 1 on the same tick -> both hp 0, both isdead=1, wins unchanged. After 180 ticks -> INTRO, isdead 0, hp 100.
- No hits for 99*60 ticks -> timer reaches 0, phase TIMEOUT, no win (tie). With hp 60 vs 52 instead -> P1 wins the round.
- P1 wins 2 rounds -> MATCH_OVER, winner=1; assert Reset mid-FIGHT in the next match -> IDLE with all reset values immediately.

Source files
------------

// File: rtl/fight_round_ctrl_pkg.sv
// Shared types and constants for the round sequencer and its per-player stats block.
// Pure declarations; no timing or flow-control behaviour.
package fight_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INTRO      = 3'd1,
    FIGHT      = 3'd2,
    KO         = 3'd3,
    TIMEOUT    = 3'd4,
    MATCH_OVER = 3'd5
  } phase_t;

  localparam int KEY_SPESH  = 7;
  localparam int KEY_KICK   = 8;
  localparam int KEY_PUNCH  = 9;
  localparam int KEY_RIGHT  = 10;
  localparam int KEY_CROUCH = 11;
  localparam int KEY_LEFT   = 12;
  localparam int KEY_JUMP   = 13;

  localparam int HP_W    = 8;
  localparam int KS_W    = 10;
  localparam int KEY_W   = 14;
  localparam int TIMER_W = 7;
  localparam int WINS_W  = 2;

  // Health never wraps: any damage at or above the current value leaves zero.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                              input logic [HP_W:0]   b);
    if ({1'b0, a} > b) return a - b[HP_W-1:0];
    else               return '0;
  endfunction

endpackage

// File: rtl/fight_round_ctrl_if.sv
// Game-side signal bundle between keyboard/fighters/HUD and the round sequencer.
// master = stimulus side (keyboard, fighters, position logic); slave = sequencer.
interface fight_round_ctrl_if;
  import fight_pkg::*;

  logic               start;
  logic [KEY_W-1:0]   key_p1;
  logic [KEY_W-1:0]   key_p2;
  logic               hit_p1;
  logic               hit_p2;
  logic               in_range;
  logic               proj_hit_p1;
  logic               proj_hit_p2;
  logic               gen_p1;
  logic               gen_p2;

  logic [KEY_W-1:0]   key_out_p1;
  logic [KEY_W-1:0]   key_out_p2;
  logic [KS_W-1:0]    ks_p1;
  logic [KS_W-1:0]    ks_p2;
  logic [HP_W-1:0]    hp_p1;
  logic [HP_W-1:0]    hp_p2;
  logic               isdead_p1;
  logic               isdead_p2;
  logic [TIMER_W-1:0] timer;
  logic [WINS_W-1:0]  wins_p1;
  logic [WINS_W-1:0]  wins_p2;
  phase_t             phase;
  logic [1:0]         winner;

  modport master (
    output start, key_p1, key_p2, hit_p1, hit_p2, in_range,
           proj_hit_p1, proj_hit_p2, gen_p1, gen_p2,
    input  key_out_p1, key_out_p2, ks_p1, ks_p2, hp_p1, hp_p2,
           isdead_p1, isdead_p2, timer, wins_p1, wins_p2, phase, winner
  );

  modport slave (
    input  start, key_p1, key_p2, hit_p1, hit_p2, in_range,
           proj_hit_p1, proj_hit_p2, gen_p1, gen_p2,
    output key_out_p1, key_out_p2, ks_p1, ks_p2, hp_p1, hp_p2,
           isdead_p1, isdead_p2, timer, wins_p1, wins_p2, phase, winner
  );

endinterface

// File: rtl/fight_round_ctrl_stats.sv
// One player's health and special meter: saturating damage, gain and clear, reload on round start.
// Updates one Clk after the tick is seen; hp_nxt is the same-tick preview; no backpressure.
module fighter_stats
  import fight_pkg::*;
#(
  parameter int HP_MAX    = 100,
  parameter int MELEE_DMG = 8,
  parameter int PROJ_DMG  = 30,
  parameter int KS_MAX    = 200,
  parameter int KS_GAIN   = 20
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            tick,
  input  logic            load,
  input  logic            fight,
  input  logic            melee_taken,
  input  logic            proj_taken,
  input  logic            melee_landed,
  input  logic            gen,
  output logic [HP_W-1:0] hp,
  output logic [HP_W-1:0] hp_nxt,
  output logic [KS_W-1:0] ks
);

  localparam logic [HP_W-1:0] HP_INIT = HP_W'(HP_MAX);
  localparam logic [HP_W:0]   MELEE_V = (HP_W+1)'(MELEE_DMG);
  localparam logic [HP_W:0]   PROJ_V  = (HP_W+1)'(PROJ_DMG);
  localparam logic [KS_W:0]   GAIN_V  = (KS_W+1)'(KS_GAIN);
  localparam logic [KS_W:0]   KS_TOP  = (KS_W+1)'(KS_MAX);

  logic [HP_W:0]   dmg;
  logic [KS_W:0]   ks_sum;
  logic [KS_W-1:0] ks_nxt;

  always_comb begin
    dmg = '0;
    if (melee_taken) dmg = dmg + MELEE_V;
    if (proj_taken)  dmg = dmg + PROJ_V;
    hp_nxt = sat_sub(hp, dmg);

    ks_sum = {1'b0, ks} + GAIN_V;
    ks_nxt = ks;
    // Spending the meter takes precedence over a gain landing on the same tick.
    if (gen)
      ks_nxt = '0;
    else if (melee_landed)
      ks_nxt = (ks_sum >= KS_TOP) ? KS_TOP[KS_W-1:0] : ks_sum[KS_W-1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hp <= HP_INIT;
      ks <= '0;
    end else if (tick) begin
      if (load) begin
        hp <= HP_INIT;
        ks <= '0;
      end else if (fight) begin
        hp <= hp_nxt;
        ks <= ks_nxt;
      end
    end
  end

endmodule

// File: rtl/fight_round_ctrl.sv
// Match/round sequencer: phases, round clock, wins, KO flags and key gating for two fighters.
// State moves one Clk after each frame tick; key gating is combinational; no backpressure.
module fight_round_ctrl
  import fight_pkg::*;
#(
  parameter int HP_MAX         = 100,
  parameter int MELEE_DMG      = 8,
  parameter int PROJ_DMG       = 30,
  parameter int KS_MAX         = 200,
  parameter int KS_GAIN        = 20,
  parameter int ROUND_SECS     = 99,
  parameter int FRAMES_PER_SEC = 60,
  parameter int INTRO_FRAMES   = 120,
  parameter int KO_FRAMES      = 180,
  parameter int WINS_NEEDED    = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  fight_round_ctrl_if.slave bus
);

  localparam int CNT_MAX = (INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int SUB_W   = $clog2(FRAMES_PER_SEC);

  localparam logic [CNT_W-1:0]   INTRO_LAST = CNT_W'(INTRO_FRAMES - 1);
  localparam logic [CNT_W-1:0]   KO_LAST    = CNT_W'(KO_FRAMES - 1);
  localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(FRAMES_PER_SEC - 1);
  localparam logic [WINS_W-1:0]  WINS_TGT   = WINS_W'(WINS_NEEDED);
  localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(ROUND_SECS);

  logic               frame_q1, frame_q2;
  phase_t             phase_r;
  logic [CNT_W-1:0]   frame_cnt;
  logic [SUB_W-1:0]   sub_cnt;
  logic [TIMER_W-1:0] timer_r;
  logic [WINS_W-1:0]  wins_p1_r, wins_p2_r;
  logic               isdead_p1_r, isdead_p2_r;
  logic [1:0]         winner_r;

  logic               tick, in_fight, melee_p1, melee_p2;
  logic               round_done, go_intro, load;
  logic [HP_W-1:0]    hp_p1, hp_p2, hp_p1_nxt, hp_p2_nxt;
  logic [KS_W-1:0]    ks_p1, ks_p2;
  logic [SUB_W-1:0]   sub_nxt;
  logic [TIMER_W-1:0] timer_nxt;

  assign tick       = frame_q1 & ~frame_q2;
  assign in_fight   = (phase_r == FIGHT);
  assign melee_p1   = bus.hit_p1 & bus.in_range;
  assign melee_p2   = bus.hit_p2 & bus.in_range;
  assign round_done = (frame_cnt == KO_LAST);
  assign load       = tick & go_intro;

  // Every path into INTRO funnels through go_intro so the stats reload on the entry tick.
  always_comb begin
    go_intro = 1'b0;
    case (phase_r)
      IDLE, MATCH_OVER: go_intro = bus.start;
      KO, TIMEOUT:      go_intro = round_done && (wins_p1_r != WINS_TGT) && (wins_p2_r != WINS_TGT);
      default:          go_intro = 1'b0;
    endcase
  end

  always_comb begin
    sub_nxt   = sub_cnt + SUB_W'(1);
    timer_nxt = timer_r;
    if (sub_cnt == SUB_LAST) begin
      sub_nxt = '0;
      if (timer_r != '0) timer_nxt = timer_r - TIMER_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_q1 <= 1'b0;
      frame_q2 <= 1'b0;
    end else begin
      frame_q1 <= frame_clk;
      frame_q2 <= frame_q1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      phase_r     <= IDLE;
      frame_cnt   <= '0;
      sub_cnt     <= '0;
      timer_r     <= TIMER_INIT;
      wins_p1_r   <= '0;
      wins_p2_r   <= '0;
      isdead_p1_r <= 1'b0;
      isdead_p2_r <= 1'b0;
      winner_r    <= 2'd0;
    end else if (tick) begin
      if (go_intro) begin
        phase_r     <= INTRO;
        frame_cnt   <= '0;
        sub_cnt     <= '0;
        timer_r     <= TIMER_INIT;
        isdead_p1_r <= 1'b0;
        isdead_p2_r <= 1'b0;
        if (phase_r == MATCH_OVER) begin
          wins_p1_r <= '0;
          wins_p2_r <= '0;
          winner_r  <= 2'd0;
        end
      end else begin
        case (phase_r)
          INTRO: begin
            if (frame_cnt == INTRO_LAST) begin
              phase_r   <= FIGHT;
              frame_cnt <= '0;
              sub_cnt   <= '0;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
          FIGHT: begin
            sub_cnt <= sub_nxt;
            timer_r <= timer_nxt;
            // Round end is judged on the values this tick produces, KO ahead of timeout.
            if (hp_p1_nxt == '0 || hp_p2_nxt == '0) begin
              phase_r     <= KO;
              frame_cnt   <= '0;
              isdead_p1_r <= (hp_p1_nxt == '0);
              isdead_p2_r <= (hp_p2_nxt == '0);
              if (hp_p1_nxt != '0 && wins_p1_r != WINS_TGT) wins_p1_r <= wins_p1_r + WINS_W'(1);
              if (hp_p2_nxt != '0 && wins_p2_r != WINS_TGT) wins_p2_r <= wins_p2_r + WINS_W'(1);
            end else if (timer_nxt == '0) begin
              phase_r   <= TIMEOUT;
              frame_cnt <= '0;
              if (hp_p1_nxt > hp_p2_nxt && wins_p1_r != WINS_TGT) wins_p1_r <= wins_p1_r + WINS_W'(1);
              if (hp_p2_nxt > hp_p1_nxt && wins_p2_r != WINS_TGT) wins_p2_r <= wins_p2_r + WINS_W'(1);
            end
          end
          KO, TIMEOUT: begin
            if (!round_done) begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end else begin
              // Reaching here means go_intro was false, so someone has hit the target.
              phase_r  <= MATCH_OVER;
              winner_r <= (wins_p1_r == WINS_TGT) ? 2'd1 : 2'd2;
            end
          end
          IDLE, MATCH_OVER: ;
          default: phase_r <= IDLE;
        endcase
      end
    end
  end

  fighter_stats #(
    .HP_MAX(HP_MAX), .MELEE_DMG(MELEE_DMG), .PROJ_DMG(PROJ_DMG),
    .KS_MAX(KS_MAX), .KS_GAIN(KS_GAIN)
  ) u_stats_p1 (
    .Clk          (Clk),
    .Reset        (Reset),
    .tick         (tick),
    .load         (load),
    .fight        (in_fight),
    .melee_taken  (melee_p2),
    .proj_taken   (bus.proj_hit_p2),
    .melee_landed (melee_p1),
    .gen          (bus.gen_p1),
    .hp           (hp_p1),
    .hp_nxt       (hp_p1_nxt),
    .ks           (ks_p1)
  );

  fighter_stats #(
    .HP_MAX(HP_MAX), .MELEE_DMG(MELEE_DMG), .PROJ_DMG(PROJ_DMG),
    .KS_MAX(KS_MAX), .KS_GAIN(KS_GAIN)
  ) u_stats_p2 (
    .Clk          (Clk),
    .Reset        (Reset),
    .tick         (tick),
    .load         (load),
    .fight        (in_fight),
    .melee_taken  (melee_p1),
    .proj_taken   (bus.proj_hit_p1),
    .melee_landed (melee_p2),
    .gen          (bus.gen_p2),
    .hp           (hp_p2),
    .hp_nxt       (hp_p2_nxt),
    .ks           (ks_p2)
  );

  assign bus.key_out_p1 = in_fight ? bus.key_p1 : '0;
  assign bus.key_out_p2 = in_fight ? bus.key_p2 : '0;
  assign bus.hp_p1      = hp_p1;
  assign bus.hp_p2      = hp_p2;
  assign bus.ks_p1      = ks_p1;
  assign bus.ks_p2      = ks_p2;
  assign bus.isdead_p1  = isdead_p1_r;
  assign bus.isdead_p2  = isdead_p2_r;
  assign bus.timer      = timer_r;
  assign bus.wins_p1    = wins_p1_r;
  assign bus.wins_p2    = wins_p2_r;
  assign bus.phase      = phase_r;
  assign bus.winner     = winner_r;

endmodule

// File: tb/tb_fight_round_ctrl.sv
// Directed bench for fight_round_ctrl: two matches covering KO, meter, double KO, timeouts and reset.
module tb_fight_round_ctrl;
  import fight_pkg::*;

  localparam logic [13:0] KEYS1 = 14'((1 << KEY_JUMP) | (1 << KEY_PUNCH) | (1 << KEY_SPESH));
  localparam logic [13:0] KEYS2 = 14'((1 << KEY_LEFT) | (1 << KEY_KICK) | (1 << KEY_CROUCH));

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frame_clk = 1'b0;
  int checks = 0;
  int passed = 0;

  fight_round_ctrl_if bus();

  fight_round_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #5 Clk = ~Clk;

  task automatic do_tick();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk) frame_clk = 1'b0;
    @(negedge Clk);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic clr_in();
    bus.start = 0; bus.hit_p1 = 0; bus.hit_p2 = 0; bus.in_range = 0;
    bus.proj_hit_p1 = 0; bus.proj_hit_p2 = 0; bus.gen_p1 = 0; bus.gen_p2 = 0;
  endtask

  task automatic test_reset();
    clr_in();
    bus.key_p1 = KEYS1; bus.key_p2 = KEYS2;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    checks++; if (bus.phase !== IDLE) $display("FAIL reset_phase got %0d want %0d", bus.phase, IDLE); else passed++;
    checks++; if (bus.hp_p1 !== 8'd100 || bus.hp_p2 !== 8'd100) $display("FAIL reset_hp got %0d/%0d want 100/100", bus.hp_p1, bus.hp_p2); else passed++;
    checks++; if (bus.ks_p1 !== 10'd0 || bus.ks_p2 !== 10'd0) $display("FAIL reset_ks got %0d/%0d want 0/0", bus.ks_p1, bus.ks_p2); else passed++;
    checks++; if (bus.timer !== 7'd99) $display("FAIL reset_timer got %0d want 99", bus.timer); else passed++;
    checks++; if (bus.wins_p1 !== 2'd0 || bus.wins_p2 !== 2'd0 || bus.winner !== 2'd0) $display("FAIL reset_wins got %0d/%0d w%0d want 0/0 w0", bus.wins_p1, bus.wins_p2, bus.winner); else passed++;
    checks++; if (bus.isdead_p1 !== 1'b0 || bus.isdead_p2 !== 1'b0) $display("FAIL reset_isdead got %b%b want 00", bus.isdead_p1, bus.isdead_p2); else passed++;
    checks++; if (bus.key_out_p1 !== 14'd0 || bus.key_out_p2 !== 14'd0) $display("FAIL reset_keygate got %h/%h want 0/0", bus.key_out_p1, bus.key_out_p2); else passed++;
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  // Leaves the DUT at the first FIGHT tick of a fresh round; expects INTRO entry on this tick.
  task automatic run_intro(input string tag);
    tick_n(119);
    checks++; if (bus.phase !== INTRO) $display("FAIL %s_intro_hold got %0d want %0d", tag, bus.phase, INTRO); else passed++;
    checks++; if (bus.key_out_p1 !== 14'd0) $display("FAIL %s_intro_keygate got %h want 0", tag, bus.key_out_p1); else passed++;
    do_tick();
    checks++; if (bus.phase !== FIGHT) $display("FAIL %s_fight_entry got %0d want %0d", tag, bus.phase, FIGHT); else passed++;
    checks++; if (bus.hp_p1 !== 8'd100 || bus.hp_p2 !== 8'd100 || bus.timer !== 7'd99) $display("FAIL %s_fight_init got hp %0d/%0d t %0d want 100/100 t 99", tag, bus.hp_p1, bus.hp_p2, bus.timer); else passed++;
  endtask

  // Waits out KO/TIMEOUT; expected next phase is INTRO or MATCH_OVER.
  task automatic run_ko_wait(input string tag, input phase_t held, input phase_t nxt);
    tick_n(179);
    checks++; if (bus.phase !== held) $display("FAIL %s_ko_hold got %0d want %0d", tag, bus.phase, held); else passed++;
    do_tick();
    checks++; if (bus.phase !== nxt) $display("FAIL %s_ko_exit got %0d want %0d", tag, bus.phase, nxt); else passed++;
  endtask

  task automatic test_intro();
    bus.start = 1; do_tick(); bus.start = 0;
    checks++; if (bus.phase !== INTRO) $display("FAIL start_intro got %0d want %0d", bus.phase, INTRO); else passed++;
    run_intro("m1r1");
    checks++; if (bus.key_out_p1 !== KEYS1 || bus.key_out_p2 !== KEYS2) $display("FAIL fight_keypass got %h/%h want %h/%h", bus.key_out_p1, bus.key_out_p2, KEYS1, KEYS2); else passed++;
  endtask

  task automatic test_melee_ko();
    bus.hit_p1 = 1; bus.in_range = 1;
    for (int k = 1; k <= 13; k++) begin
      int exp_hp, exp_ks;
      do_tick();
      exp_hp = (k < 13) ? 100 - 8 * k : 0;
      exp_ks = (20 * k > 200) ? 200 : 20 * k;
      checks++; if (bus.hp_p2 !== 8'(exp_hp)) $display("FAIL melee_hp_p2 hit %0d got %0d want %0d", k, bus.hp_p2, exp_hp); else passed++;
      checks++; if (bus.ks_p1 !== 10'(exp_ks)) $display("FAIL melee_ks_p1 hit %0d got %0d want %0d", k, bus.ks_p1, exp_ks); else passed++;
    end
    clr_in();
    checks++; if (bus.phase !== KO) $display("FAIL ko_phase got %0d want %0d", bus.phase, KO); else passed++;
    checks++; if (bus.isdead_p2 !== 1'b1 || bus.isdead_p1 !== 1'b0) $display("FAIL ko_isdead got p1 %b p2 %b want 0 1", bus.isdead_p1, bus.isdead_p2); else passed++;
    checks++; if (bus.wins_p1 !== 2'd1 || bus.wins_p2 !== 2'd0) $display("FAIL ko_wins got %0d/%0d want 1/0", bus.wins_p1, bus.wins_p2); else passed++;
    checks++; if (bus.hp_p1 !== 8'd100) $display("FAIL ko_hp_p1 got %0d want 100", bus.hp_p1); else passed++;
    checks++; if (bus.key_out_p1 !== 14'd0) $display("FAIL ko_keygate got %h want 0", bus.key_out_p1); else passed++;
    run_ko_wait("m1r1", KO, INTRO);
    checks++; if (bus.isdead_p2 !== 1'b0 || bus.hp_p2 !== 8'd100 || bus.ks_p1 !== 10'd0) $display("FAIL reintro got dead %b hp %0d ks %0d want 0 100 0", bus.isdead_p2, bus.hp_p2, bus.ks_p1); else passed++;
    run_intro("m1r2");
  endtask

  task automatic test_gen_proj();
    bus.hit_p1 = 1; bus.in_range = 1;
    tick_n(9);
    checks++; if (bus.ks_p1 !== 10'd180) $display("FAIL ks_nine got %0d want 180", bus.ks_p1); else passed++;
    do_tick();
    checks++; if (bus.ks_p1 !== 10'd200 || bus.hp_p2 !== 8'd20) $display("FAIL ks_full got ks %0d hp %0d want 200 20", bus.ks_p1, bus.hp_p2); else passed++;
    bus.gen_p1 = 1; do_tick(); clr_in();
    checks++; if (bus.ks_p1 !== 10'd0) $display("FAIL gen_beats_gain got %0d want 0", bus.ks_p1); else passed++;
    checks++; if (bus.hp_p2 !== 8'd12) $display("FAIL gen_hit_hp got %0d want 12", bus.hp_p2); else passed++;
    bus.proj_hit_p1 = 1; do_tick(); clr_in();
    checks++; if (bus.hp_p2 !== 8'd0 || bus.phase !== KO) $display("FAIL proj_sat got hp %0d ph %0d want 0 %0d", bus.hp_p2, bus.phase, KO); else passed++;
    checks++; if (bus.wins_p1 !== 2'd2) $display("FAIL second_win got %0d want 2", bus.wins_p1); else passed++;
    run_ko_wait("m1r2", KO, MATCH_OVER);
    checks++; if (bus.winner !== 2'd1) $display("FAIL winner got %0d want 1", bus.winner); else passed++;
    bus.hit_p2 = 1; bus.in_range = 1; bus.proj_hit_p2 = 1; bus.gen_p1 = 1;
    do_tick(); clr_in();
    checks++; if (bus.phase !== MATCH_OVER || bus.hp_p1 !== 8'd100 || bus.hp_p2 !== 8'd0) $display("FAIL over_hold got ph %0d hp %0d/%0d want %0d 100/0", bus.phase, bus.hp_p1, bus.hp_p2, MATCH_OVER); else passed++;
    checks++; if (bus.wins_p1 !== 2'd2 || bus.winner !== 2'd1) $display("FAIL over_wins got %0d w%0d want 2 w1", bus.wins_p1, bus.winner); else passed++;
  endtask

  task automatic test_double_ko();
    bus.start = 1; do_tick(); bus.start = 0;
    checks++; if (bus.phase !== INTRO || bus.wins_p1 !== 2'd0 || bus.winner !== 2'd0 || bus.hp_p2 !== 8'd100) $display("FAIL restart got ph %0d w %0d win %0d hp %0d want %0d 0 0 100", bus.phase, bus.wins_p1, bus.winner, bus.hp_p2, INTRO); else passed++;
    run_intro("m2r1");
    bus.hit_p1 = 1; bus.hit_p2 = 1; bus.in_range = 1;
    tick_n(12);
    checks++; if (bus.hp_p1 !== 8'd4 || bus.hp_p2 !== 8'd4) $display("FAIL dko_pre got %0d/%0d want 4/4", bus.hp_p1, bus.hp_p2); else passed++;
    checks++; if (bus.ks_p1 !== 10'd200 || bus.ks_p2 !== 10'd200) $display("FAIL dko_ks got %0d/%0d want 200/200", bus.ks_p1, bus.ks_p2); else passed++;
    do_tick(); clr_in();
    checks++; if (bus.hp_p1 !== 8'd0 || bus.hp_p2 !== 8'd0 || bus.phase !== KO) $display("FAIL dko got hp %0d/%0d ph %0d want 0/0 %0d", bus.hp_p1, bus.hp_p2, bus.phase, KO); else passed++;
    checks++; if (bus.isdead_p1 !== 1'b1 || bus.isdead_p2 !== 1'b1) $display("FAIL dko_isdead got %b%b want 11", bus.isdead_p1, bus.isdead_p2); else passed++;
    checks++; if (bus.wins_p1 !== 2'd0 || bus.wins_p2 !== 2'd0) $display("FAIL dko_wins got %0d/%0d want 0/0", bus.wins_p1, bus.wins_p2); else passed++;
    run_ko_wait("m2r1", KO, INTRO);
    checks++; if (bus.isdead_p1 !== 1'b0 || bus.isdead_p2 !== 1'b0 || bus.hp_p1 !== 8'd100) $display("FAIL dko_reintro got dead %b%b hp %0d want 00 100", bus.isdead_p1, bus.isdead_p2, bus.hp_p1); else passed++;
    run_intro("m2r2");
  endtask

  task automatic test_timeout_tie();
    bus.proj_hit_p1 = 1; bus.proj_hit_p2 = 1; do_tick(); clr_in();
    checks++; if (bus.hp_p1 !== 8'd70 || bus.hp_p2 !== 8'd70) $display("FAIL proj_both got %0d/%0d want 70/70", bus.hp_p1, bus.hp_p2); else passed++;
    tick_n(59);
    checks++; if (bus.timer !== 7'd98) $display("FAIL timer_one_sec got %0d want 98", bus.timer); else passed++;
    tick_n(5879);
    checks++; if (bus.timer !== 7'd1 || bus.phase !== FIGHT) $display("FAIL timer_last got t %0d ph %0d want 1 %0d", bus.timer, bus.phase, FIGHT); else passed++;
    do_tick();
    checks++; if (bus.timer !== 7'd0 || bus.phase !== TIMEOUT) $display("FAIL timeout got t %0d ph %0d want 0 %0d", bus.timer, bus.phase, TIMEOUT); else passed++;
    checks++; if (bus.wins_p1 !== 2'd0 || bus.wins_p2 !== 2'd0 || bus.isdead_p1 !== 1'b0 || bus.isdead_p2 !== 1'b0) $display("FAIL tie_result got w %0d/%0d dead %b%b want 0/0 00", bus.wins_p1, bus.wins_p2, bus.isdead_p1, bus.isdead_p2); else passed++;
    run_ko_wait("m2r2", TIMEOUT, INTRO);
    run_intro("m2r3");
  endtask

  task automatic test_timeout_win();
    bus.hit_p1 = 1; bus.hit_p2 = 1; bus.in_range = 1; tick_n(5);
    bus.hit_p2 = 0; do_tick(); clr_in();
    checks++; if (bus.hp_p1 !== 8'd60 || bus.hp_p2 !== 8'd52) $display("FAIL lead_hp got %0d/%0d want 60/52", bus.hp_p1, bus.hp_p2); else passed++;
    tick_n(5933);
    checks++; if (bus.phase !== FIGHT || bus.timer !== 7'd1) $display("FAIL lead_last got ph %0d t %0d want %0d 1", bus.phase, bus.timer, FIGHT); else passed++;
    do_tick();
    checks++; if (bus.phase !== TIMEOUT || bus.wins_p1 !== 2'd1 || bus.wins_p2 !== 2'd0) $display("FAIL lead_win got ph %0d w %0d/%0d want %0d 1/0", bus.phase, bus.wins_p1, bus.wins_p2, TIMEOUT); else passed++;
    run_ko_wait("m2r3", TIMEOUT, INTRO);
    run_intro("m2r4");
  endtask

  task automatic test_reset_mid();
    bus.hit_p1 = 1; bus.in_range = 1; do_tick(); clr_in();
    checks++; if (bus.hp_p2 !== 8'd92 || bus.ks_p1 !== 10'd20) $display("FAIL pre_abort got hp %0d ks %0d want 92 20", bus.hp_p2, bus.ks_p1); else passed++;
    @(negedge Clk); #2 Reset = 1'b1; #1;
    checks++; if (bus.phase !== IDLE || bus.hp_p2 !== 8'd100 || bus.ks_p1 !== 10'd0) $display("FAIL abort_state got ph %0d hp %0d ks %0d want %0d 100 0", bus.phase, bus.hp_p2, bus.ks_p1, IDLE); else passed++;
    checks++; if (bus.wins_p1 !== 2'd0 || bus.timer !== 7'd99 || bus.key_out_p1 !== 14'd0) $display("FAIL abort_misc got w %0d t %0d k %h want 0 99 0", bus.wins_p1, bus.timer, bus.key_out_p1); else passed++;
    @(negedge Clk) Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_intro();
    test_melee_ko();
    test_gen_proj();
    test_double_ko();
    test_timeout_tie();
    test_timeout_win();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
